// File: rtl/branch_pc_unit.sv
// Fetch PC owner and control-transfer resolver: sequences the PC, redirects on
// taken branch/JAL/JALR, holds a multi-cycle flush and flags misaligned targets.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_c,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_c,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        flag,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] pc,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] link_addr,
  output logic        flush,
  output logic        misalign_exc,
  output logic        dbg_state
);

  // Handshake: an EX instruction is consumed only when ex_valid is high and
  // the unit is in RUN; there is no backpressure toward EX.
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] jalr_sum;
  logic [31:0] rel_sum;
  logic        act;
  logic        taken;
  logic        misaligned;

  assign dbg_state = state;

  always_comb begin
    jalr_sum   = rs1 + imm;
    rel_sum    = ex_pc + imm;
    // jalr wins over jal/branch when several type bits are set
    target     = is_jalr ? {jalr_sum[31:1], 1'b0} : rel_sum;
    link_addr  = ex_pc + (ex_c ? 32'd2 : 32'd4);
    act        = ex_valid && (state == RUN) && !rst;
    taken      = act && (is_jalr || is_jal || (is_branch && flag));
    misaligned = taken && !is_jalr && rel_sum[0];
    redirect   = taken;
    flush      = !rst && (taken || (state == FLUSH));
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (taken && (FLUSH_CYCLES > 1)) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_LOAD;
        end
      end
      FLUSH: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    if (misaligned)  pc_nxt = TRAP_VEC;
    else if (taken)  pc_nxt = target;
    else if (!stall) pc_nxt = pc + (fetch_c ? 32'd2 : 32'd4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      state        <= RUN;
      cnt          <= 3'd0;
      misalign_exc <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      misalign_exc <= misaligned;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model of the PC stage.
module tb_branch_pc_unit;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst, stall, fetch_c, ex_valid, ex_c;
  logic        is_branch, is_jal, is_jalr, flag;
  logic [31:0] ex_pc, imm, rs1;
  logic [31:0] pc, target, link_addr;
  logic        redirect, flush, misalign_exc, dbg_state;

  int errs = 0;
  int checks = 0;

  // model state: fetch pc, flush cycles still owed after this one, exc pulse
  logic [31:0] m_pc = 32'h0;
  int          m_left = 0;
  logic        m_exc = 1'b0;

  branch_pc_unit #(
    .RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_c(fetch_c),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_c(ex_c),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .flag(flag), .imm(imm), .rs1(rs1),
    .pc(pc), .redirect(redirect), .target(target), .link_addr(link_addr),
    .flush(flush), .misalign_exc(misalign_exc), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_target();
    logic [31:0] s;
    if (is_jalr) begin
      s = rs1 + imm;
      return s & 32'hFFFF_FFFE;
    end
    return ex_pc + imm;
  endfunction

  function automatic bit m_taken();
    return !rst && ex_valid && (m_left == 0) &&
           (is_jalr || is_jal || (is_branch && flag));
  endfunction

  task automatic clear_ex();
    ex_valid = 0; ex_c = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    flag = 0; ex_pc = 0; imm = 0; rs1 = 0;
  endtask

  task automatic drive_ex(input logic b, input logic j, input logic jr,
                          input logic f, input logic [31:0] epc,
                          input logic [31:0] im, input logic [31:0] r1,
                          input logic c);
    ex_valid = 1; is_branch = b; is_jal = j; is_jalr = jr; flag = f;
    ex_pc = epc; imm = im; rs1 = r1; ex_c = c;
  endtask

  // advance one clock and move the model by the rules of the PC stage
  task automatic tick();
    logic [31:0] t;
    bit tk, mis;
    tk  = m_taken();
    t   = m_target();
    mis = tk && !is_jalr && t[0];
    @(posedge clk); #1;
    if (rst) begin
      m_pc = RESET_PC; m_left = 0; m_exc = 0;
    end else if (tk) begin
      m_pc = mis ? TRAP_VEC : t; m_exc = mis; m_left = FLUSH_CYCLES - 1;
    end else begin
      m_exc = 0;
      if (m_left > 0) m_left--;
      if (!stall) m_pc = m_pc + (fetch_c ? 32'd2 : 32'd4);
    end
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; fetch_c = 0; clear_ex();
    drive_ex(0, 1, 0, 0, 32'h40, 32'h8, 32'h0, 0);
    #1;
    checks++; if (redirect !== 1'b0) begin errs++; $display("FAIL reset_redirect: got %b want 0", redirect); end
    checks++; if (flush !== 1'b0) begin errs++; $display("FAIL reset_flush: got %b want 0", flush); end
    tick(); tick();
    clear_ex(); rst = 0; #1;
    checks++; if (pc !== RESET_PC) begin errs++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    checks++; if (misalign_exc !== 1'b0) begin errs++; $display("FAIL reset_exc: got %b want 0", misalign_exc); end
    checks++; if (dbg_state !== 1'b0) begin errs++; $display("FAIL reset_state: got %b want 0", dbg_state); end
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc [3];
    logic        fc [3];
    exp_pc[0] = 32'd4; exp_pc[1] = 32'd6; exp_pc[2] = 32'd10;
    fc[0] = 0; fc[1] = 1; fc[2] = 0;
    for (int i = 0; i < 3; i++) begin
      fetch_c = fc[i];
      tick();
      checks++; if (pc !== exp_pc[i]) begin errs++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp_pc[i]); end
    end
    fetch_c = 0;
  endtask

  task automatic test_beq_taken();
    drive_ex(1, 0, 0, 1, 32'h40, 32'h20, 32'h0, 0); #1;
    checks++; if (redirect !== 1'b1) begin errs++; $display("FAIL beq_redirect: got %b want 1", redirect); end
    checks++; if (target !== 32'h60) begin errs++; $display("FAIL beq_target: got %h want 60", target); end
    checks++; if (flush !== 1'b1) begin errs++; $display("FAIL beq_flush_n: got %b want 1", flush); end
    tick(); clear_ex(); #1;
    checks++; if (pc !== 32'h60) begin errs++; $display("FAIL beq_pc: got %h want 60", pc); end
    checks++; if (flush !== 1'b1) begin errs++; $display("FAIL beq_flush_n1: got %b want 1", flush); end
    checks++; if (redirect !== 1'b0) begin errs++; $display("FAIL beq_redirect_n1: got %b want 0", redirect); end
    tick(); #1;
    checks++; if (flush !== 1'b0) begin errs++; $display("FAIL beq_flush_n2: got %b want 0", flush); end
    checks++; if (pc !== 32'h64) begin errs++; $display("FAIL beq_pc_n2: got %h want 64", pc); end
  endtask

  task automatic test_not_taken_stall();
    stall = 1;
    drive_ex(1, 0, 0, 0, 32'h50, 32'h40, 32'h0, 0); #1;
    checks++; if (redirect !== 1'b0) begin errs++; $display("FAIL bne_redirect: got %b want 0", redirect); end
    checks++; if (flush !== 1'b0) begin errs++; $display("FAIL bne_flush: got %b want 0", flush); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'h64) begin errs++; $display("FAIL stall_pc%0d: got %h want 64", i, pc); end
    end
    stall = 0; clear_ex();
  endtask

  task automatic test_jalr();
    drive_ex(0, 0, 1, 0, 32'h80, 32'h4, 32'h1001, 1); #1;
    checks++; if (target !== 32'h1004) begin errs++; $display("FAIL jalr_target: got %h want 1004", target); end
    checks++; if (link_addr !== 32'h82) begin errs++; $display("FAIL jalr_link: got %h want 82", link_addr); end
    checks++; if (redirect !== 1'b1) begin errs++; $display("FAIL jalr_redirect: got %b want 1", redirect); end
    tick();
    drive_ex(1, 0, 0, 1, 32'h300, 32'h8, 32'h0, 0); #1;
    checks++; if (redirect !== 1'b0) begin errs++; $display("FAIL jalr_second_ignored: got %b want 0", redirect); end
    checks++; if (pc !== 32'h1004) begin errs++; $display("FAIL jalr_pc: got %h want 1004", pc); end
    tick(); clear_ex(); #1;
    checks++; if (pc !== 32'h1008) begin errs++; $display("FAIL jalr_pc_after: got %h want 1008", pc); end
  endtask

  task automatic test_jal_misalign();
    drive_ex(0, 1, 0, 0, 32'h200, 32'h11, 32'h0, 0); #1;
    checks++; if (target !== 32'h211) begin errs++; $display("FAIL mis_target: got %h want 211", target); end
    tick(); clear_ex(); #1;
    checks++; if (pc !== TRAP_VEC) begin errs++; $display("FAIL mis_pc: got %h want %h", pc, TRAP_VEC); end
    checks++; if (misalign_exc !== 1'b1) begin errs++; $display("FAIL mis_exc_n1: got %b want 1", misalign_exc); end
    tick(); #1;
    checks++; if (misalign_exc !== 1'b0) begin errs++; $display("FAIL mis_exc_n2: got %b want 0", misalign_exc); end
  endtask

  task automatic test_reset_mid_flush();
    drive_ex(0, 1, 0, 0, 32'h400, 32'h10, 32'h0, 0);
    tick(); #1;
    checks++; if (dbg_state !== 1'b1) begin errs++; $display("FAIL rmf_in_flush: got %b want 1", dbg_state); end
    rst = 1; #1;
    checks++; if (flush !== 1'b0) begin errs++; $display("FAIL rmf_flush_rst: got %b want 0", flush); end
    tick(); rst = 0; clear_ex(); #1;
    checks++; if (pc !== RESET_PC) begin errs++; $display("FAIL rmf_pc: got %h want %h", pc, RESET_PC); end
    checks++; if (flush !== 1'b0) begin errs++; $display("FAIL rmf_flush: got %b want 0", flush); end
    checks++; if (dbg_state !== 1'b0) begin errs++; $display("FAIL rmf_state: got %b want 0", dbg_state); end
  endtask

  task automatic test_wrap();
    drive_ex(0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0, 0);
    tick(); clear_ex(); #1;
    checks++; if (pc !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_pre: got %h want fffffffc", pc); end
    tick(); #1;
    checks++; if (pc !== 32'h0) begin errs++; $display("FAIL wrap_pc: got %h want 0", pc); end
  endtask

  task automatic test_random();
    bit tk;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 40) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      fetch_c   = 1'($urandom_range(0, 1));
      ex_valid  = ($urandom_range(0, 3) != 0);
      ex_c      = 1'($urandom_range(0, 1));
      is_branch = ($urandom_range(0, 2) == 0);
      is_jal    = ($urandom_range(0, 3) == 0);
      is_jalr   = ($urandom_range(0, 3) == 0);
      flag      = 1'($urandom_range(0, 1));
      ex_pc     = $urandom & 32'hFFFF_FFFE;
      imm       = $urandom;
      rs1       = $urandom;
      #1;
      tk = m_taken();
      checks++; if (redirect !== tk) begin errs++; $display("FAIL rnd_redirect@%0d: got %b want %b", i, redirect, tk); end
      checks++; if (flush !== (!rst && (tk || m_left > 0))) begin errs++; $display("FAIL rnd_flush@%0d: got %b", i, flush); end
      checks++; if (target !== m_target()) begin errs++; $display("FAIL rnd_target@%0d: got %h want %h", i, target, m_target()); end
      checks++; if (link_addr !== ex_pc + (ex_c ? 32'd2 : 32'd4)) begin errs++; $display("FAIL rnd_link@%0d: got %h", i, link_addr); end
      checks++; if (pc !== m_pc) begin errs++; $display("FAIL rnd_pc@%0d: got %h want %h", i, pc, m_pc); end
      checks++; if (misalign_exc !== m_exc) begin errs++; $display("FAIL rnd_exc@%0d: got %b want %b", i, misalign_exc, m_exc); end
      checks++; if (dbg_state !== (m_left > 0)) begin errs++; $display("FAIL rnd_state@%0d: got %b want %b", i, dbg_state, m_left > 0); end
      tick();
    end
    rst = 0; stall = 0; clear_ex();
  endtask

  initial begin
    test_reset();
    test_seq();
    test_beq_taken();
    test_not_taken_stall();
    test_jalr();
    test_jal_misalign();
    test_reset_mid_flush();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
